// File: rtl/drac_pkg.sv
// Shared definitions for the instruction-queue issue path.
//   ISSUE_WIDTH          : number of queue read ports / rename slots per cycle
//   IQ_FLUSH_HOLD_CYCLES : default number of pop-blocked cycles after a flush
//   iq_ctrl_state_t      : issue controller FSM state
//   iq_thermo()          : pop count -> per-slot valid thermometer
package drac_pkg;

   localparam int unsigned ISSUE_WIDTH          = 2;
   localparam int unsigned IQ_FLUSH_HOLD_CYCLES = 2;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      SERIAL_WAIT = 2'd1,
      FLUSH_HOLD  = 2'd2
   } iq_ctrl_state_t;

   function automatic logic [ISSUE_WIDTH-1:0] iq_thermo(input logic [1:0] cnt);
      logic [ISSUE_WIDTH-1:0] v;
      v = '0;
      if (cnt >= 2'd1) v[0] = 1'b1;
      if (cnt >= 2'd2) v[1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/iq_credit_counter.sv
// In-flight instruction counter for the issue controller.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clear_i       : drop all in-flight instructions (flush); commits ignored
//   pop_i         : instructions issued this cycle (0..2)
//   commit_i      : instructions retired this cycle (0..2)
//   count_o       : current in-flight count
//   free_o        : MAX_INFLIGHT - count_o
module iq_credit_counter
   import drac_pkg::*;
#(
   parameter  int unsigned MAX_INFLIGHT = 16,
   localparam int unsigned CRED_W       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              clear_i,
   input  logic [1:0]        pop_i,
   input  logic [1:0]        commit_i,
   output logic [CRED_W-1:0] count_o,
   output logic [CRED_W-1:0] free_o
);

   localparam int unsigned SUM_W = CRED_W + 1;

   logic [CRED_W-1:0] count_q, count_d;
   logic [SUM_W-1:0]  sum;

   // One extra bit so an over-commit shows up as a set MSB instead of wrapping silently.
   always_comb begin
      sum     = {1'b0, count_q} + SUM_W'(pop_i) - SUM_W'(commit_i);
      count_d = clear_i ? '0 : sum[CRED_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;
   assign free_o  = CRED_W'(MAX_INFLIGHT) - count_q;

   a_no_overcommit : assert property (@(posedge clk_i) disable iff (!rstn_i)
      !clear_i |-> (!sum[CRED_W] && (sum <= SUM_W'(MAX_INFLIGHT))));

endmodule

// File: rtl/iq_issue_ctrl.sv
// Dequeue scheduler for the dual-read instruction queue between ID and rename.
// Decides each cycle how many head entries (0/1/2) to pop, honouring downstream
// readiness, in-flight credits, serializing instructions and flush recovery.
// Ports:
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   flush_i        : pipeline flush, highest priority
//   iq_num_i       : queue occupancy
//   iq_serial_i    : [0] head serializing, [1] head+1 serializing
//   rn_ready_i     : rename accepts up to two instructions
//   commit_cnt_i   : instructions retired this cycle
//   serial_done_i  : outstanding serializing instruction committed
//   pop_cnt_o      : entries popped this cycle (combinational)
//   slot_valid_o   : thermometer of pop_cnt_o
//   inflight_o     : popped-but-uncommitted count
//   state_o        : FSM state for debug/perf
module iq_issue_ctrl
   import drac_pkg::*;
#(
   parameter  int unsigned NUM_ENTRIES       = 8,
   parameter  int unsigned MAX_INFLIGHT      = 16,
   parameter  int unsigned FLUSH_HOLD_CYCLES = IQ_FLUSH_HOLD_CYCLES,
   localparam int unsigned CNT_W             = $clog2(NUM_ENTRIES) + 1,
   localparam int unsigned CRED_W            = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   flush_i,
   input  logic [CNT_W-1:0]       iq_num_i,
   input  logic [1:0]             iq_serial_i,
   input  logic                   rn_ready_i,
   input  logic [1:0]             commit_cnt_i,
   input  logic                   serial_done_i,
   output logic [1:0]             pop_cnt_o,
   output logic [ISSUE_WIDTH-1:0] slot_valid_o,
   output logic [CRED_W-1:0]      inflight_o,
   output logic [1:0]             state_o
);

   localparam int unsigned HOLD_W = $clog2(FLUSH_HOLD_CYCLES + 1);

   iq_ctrl_state_t    state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        pop;
   logic [1:0]        num_lim, cred_lim, cap;
   logic              head_serial, next_serial;
   logic [CRED_W-1:0] inflight, free;

   iq_credit_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_credit (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clear_i  (flush_i),
      .pop_i    (pop_cnt_o),
      .commit_i (commit_cnt_i),
      .count_o  (inflight),
      .free_o   (free)
   );

   // Serial flags only count for slots that actually hold an entry.
   always_comb begin
      head_serial = iq_serial_i[0] && (iq_num_i >= CNT_W'(1));
      next_serial = iq_serial_i[1] && (iq_num_i >= CNT_W'(2));
      num_lim     = (iq_num_i >= CNT_W'(2)) ? 2'd2 : iq_num_i[1:0];
      cred_lim    = (free >= CRED_W'(2)) ? 2'd2 : free[1:0];
      cap         = (num_lim < cred_lim) ? num_lim : cred_lim;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pop     = 2'd0;
      if (flush_i) begin
         state_d = FLUSH_HOLD;
         hold_d  = HOLD_W'(FLUSH_HOLD_CYCLES);
      end else begin
         unique case (state_q)
            RUN: begin
               if (rn_ready_i) begin
                  if (head_serial) begin
                     // Serializing head issues alone, only once everything older has committed.
                     if (inflight == '0) begin
                        pop     = 2'd1;
                        state_d = SERIAL_WAIT;
                     end
                  end else if (next_serial) begin
                     pop = (cap > 2'd1) ? 2'd1 : cap;
                  end else begin
                     pop = cap;
                  end
               end
            end
            SERIAL_WAIT: begin
               if (serial_done_i) state_d = RUN;
            end
            FLUSH_HOLD: begin
               if (hold_q <= HOLD_W'(1)) begin
                  state_d = RUN;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= RUN;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign pop_cnt_o    = rstn_i ? pop : 2'd0;
   assign slot_valid_o = iq_thermo(pop_cnt_o);
   assign inflight_o   = inflight;
   assign state_o      = state_q;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
module tb_iq_issue_ctrl;

   typedef struct {
      bit flush;
      int num;
      bit [1:0] serial;
      bit rdy;
      int commit;
      bit sdone;
   } stim_t;

   typedef struct {
      int state;
      int inflight;
      int hold;
   } mst_t;

   typedef struct {
      int pop;
      int slot;
      int state;
      int inflight;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       flush_i;
   logic [3:0] iq_num_i;
   logic [1:0] iq_serial_i;
   logic       rn_ready_i;
   logic [1:0] commit_cnt_i;
   logic       serial_done_i;
   logic [1:0] pop_cnt_o;
   logic [1:0] slot_valid_o;
   logic [4:0] inflight_o;
   logic [1:0] state_o;

   logic [3:0] b_num;
   logic       b_rdy;
   logic [1:0] b_commit;
   logic [1:0] b_pop;
   logic [1:0] b_slot;
   logic [2:0] b_inflight;
   logic [1:0] b_state;

   int   n_checks = 0;
   int   n_errors = 0;
   mst_t m;
   exp_t sb_q[$];

   always #5 clk_i = ~clk_i;

   iq_issue_ctrl u_dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .flush_i       (flush_i),
      .iq_num_i      (iq_num_i),
      .iq_serial_i   (iq_serial_i),
      .rn_ready_i    (rn_ready_i),
      .commit_cnt_i  (commit_cnt_i),
      .serial_done_i (serial_done_i),
      .pop_cnt_o     (pop_cnt_o),
      .slot_valid_o  (slot_valid_o),
      .inflight_o    (inflight_o),
      .state_o       (state_o)
   );

   iq_issue_ctrl #(.MAX_INFLIGHT(4)) u_dut4 (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .flush_i       (1'b0),
      .iq_num_i      (b_num),
      .iq_serial_i   (2'b00),
      .rn_ready_i    (b_rdy),
      .commit_cnt_i  (b_commit),
      .serial_done_i (1'b0),
      .pop_cnt_o     (b_pop),
      .slot_valid_o  (b_slot),
      .inflight_o    (b_inflight),
      .state_o       (b_state)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic stim_t S(input bit fl, input int num, input bit [1:0] ser,
                               input bit rdy, input int cm, input bit sd);
      stim_t s;
      s.flush = fl; s.num = num; s.serial = ser; s.rdy = rdy; s.commit = cm; s.sdone = sd;
      return s;
   endfunction

   // Reference model: outputs visible during the cycle.
   function automatic exp_t m_out(input mst_t st, input stim_t s, input int max_if);
      exp_t e;
      int   cap;
      e.state    = st.state;
      e.inflight = st.inflight;
      e.pop      = 0;
      if (!s.flush && st.state == 0 && s.rdy) begin
         cap = (s.num < 2) ? s.num : 2;
         if (cap > max_if - st.inflight) cap = max_if - st.inflight;
         if (s.serial[0] && s.num >= 1)      e.pop = (st.inflight == 0) ? 1 : 0;
         else if (s.serial[1] && s.num >= 2) e.pop = (cap > 1) ? 1 : cap;
         else                                e.pop = cap;
      end
      e.slot = (e.pop == 2) ? 3 : (e.pop == 1) ? 1 : 0;
      return e;
   endfunction

   function automatic mst_t m_next(input mst_t st, input stim_t s, input int pop);
      mst_t n;
      n = st;
      if (s.flush) begin
         n.state = 2; n.hold = 2; n.inflight = 0;
      end else begin
         n.inflight = st.inflight + pop - s.commit;
         case (st.state)
            0: if (s.serial[0] && s.num >= 1 && pop == 1) n.state = 1;
            1: if (s.sdone) n.state = 0;
            default: begin
               if (st.hold <= 1) begin n.state = 0; n.hold = 0; end
               else n.hold = st.hold - 1;
            end
         endcase
      end
      return n;
   endfunction

   task automatic step(input int idx, input stim_t s);
      exp_t e;
      @(negedge clk_i);
      flush_i       = s.flush;
      iq_num_i      = 4'(s.num);
      iq_serial_i   = s.serial;
      rn_ready_i    = s.rdy;
      commit_cnt_i  = 2'(s.commit);
      serial_done_i = s.sdone;
      e = m_out(m, s, 16);
      sb_q.push_back(e);
      m = m_next(m, s, e.pop);
      #2;
      if (sb_q.size() == 0) begin
         chk($sformatf("r%0d sb_empty", idx), 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("r%0d pop", idx), int'(pop_cnt_o), e.pop);
         chk($sformatf("r%0d slot", idx), int'(slot_valid_o), e.slot);
         chk($sformatf("r%0d state", idx), int'(state_o), e.state);
         chk($sformatf("r%0d inflight", idx), int'(inflight_o), e.inflight);
      end
   endtask

   stim_t rows[$];

   int b_num_t[5]  = '{4, 1, 4, 4, 4};
   int b_cm_t[5]   = '{0, 0, 2, 0, 0};
   int b_pop_e[5]  = '{2, 1, 1, 2, 0};
   int b_inf_e[5]  = '{0, 2, 3, 2, 4};
   int b_slot_e[5] = '{3, 1, 1, 3, 0};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_i = 1'b0; flush_i = 1'b0; iq_num_i = 4'd5; iq_serial_i = 2'b00;
      rn_ready_i = 1'b1; commit_cnt_i = 2'd0; serial_done_i = 1'b0;
      b_num = 4'd0; b_rdy = 1'b0; b_commit = 2'd0;
      m = '{0, 0, 0};
      #12;
      chk("rst pop", int'(pop_cnt_o), 0);
      chk("rst slot", int'(slot_valid_o), 0);
      chk("rst state", int'(state_o), 0);
      chk("rst inflight", int'(inflight_o), 0);
      @(negedge clk_i);
      iq_num_i = 4'd0; rn_ready_i = 1'b0;
      rstn_i = 1'b1;

      // occupancy-limited pops, then empty queue, then not-ready with commits
      rows.push_back(S(0, 5, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 3, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 1, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 0, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 6, 2'b00, 0, 1, 0));
      rows.push_back(S(0, 6, 2'b00, 0, 2, 0));
      rows.push_back(S(0, 6, 2'b00, 0, 1, 0));
      // serializing sequence
      rows.push_back(S(0, 4, 2'b10, 1, 0, 0));
      rows.push_back(S(0, 3, 2'b01, 1, 0, 0));
      rows.push_back(S(0, 3, 2'b01, 1, 2, 0));
      rows.push_back(S(0, 3, 2'b01, 1, 0, 0));
      rows.push_back(S(0, 2, 2'b01, 1, 0, 0));
      rows.push_back(S(0, 2, 2'b01, 1, 0, 1));
      rows.push_back(S(0, 2, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 0, 2'b00, 0, 2, 0));
      rows.push_back(S(0, 0, 2'b00, 0, 1, 0));
      rows.push_back(S(0, 4, 2'b01, 1, 0, 0));
      // flush in SERIAL_WAIT, hold, resume
      rows.push_back(S(1, 4, 2'b00, 1, 1, 0));
      rows.push_back(S(0, 4, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 4, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 4, 2'b00, 1, 0, 0));
      // flush in RUN ignoring commit, reload during hold
      rows.push_back(S(1, 4, 2'b00, 1, 1, 0));
      rows.push_back(S(1, 4, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 4, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 4, 2'b00, 1, 0, 0));
      // credit boundary: fill to MAX_INFLIGHT
      rows.push_back(S(0, 1, 2'b00, 1, 0, 0));
      for (int i = 0; i < 9; i++) rows.push_back(S(0, 8, 2'b00, 1, 0, 0));
      rows.push_back(S(0, 8, 2'b00, 1, 2, 0));
      // serial flags on empty slots are ignored
      rows.push_back(S(0, 1, 2'b10, 1, 0, 0));
      rows.push_back(S(0, 0, 2'b01, 1, 0, 0));
      // drain through a flush and park in SERIAL_WAIT
      rows.push_back(S(1, 0, 2'b00, 0, 0, 0));
      rows.push_back(S(0, 0, 2'b00, 0, 0, 0));
      rows.push_back(S(0, 0, 2'b00, 0, 0, 0));
      rows.push_back(S(0, 3, 2'b01, 1, 0, 0));
      rows.push_back(S(0, 3, 2'b01, 1, 0, 0));

      foreach (rows[i]) step(i, rows[i]);

      // asynchronous reset mid-cycle while in SERIAL_WAIT
      @(negedge clk_i);
      #1;
      rstn_i = 1'b0; iq_serial_i = 2'b00; iq_num_i = 4'd5; rn_ready_i = 1'b1;
      #1;
      chk("arst pop", int'(pop_cnt_o), 0);
      chk("arst slot", int'(slot_valid_o), 0);
      chk("arst state", int'(state_o), 0);
      chk("arst inflight", int'(inflight_o), 0);
      @(negedge clk_i);
      chk("arst hold pop", int'(pop_cnt_o), 0);
      iq_num_i = 4'd0; rn_ready_i = 1'b0;
      rstn_i = 1'b1;
      m = '{0, 0, 0};
      step(100, S(0, 5, 2'b00, 1, 0, 0));

      // MAX_INFLIGHT=4 instance: credit-limited pops with same-cycle commit
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         b_num = 4'(b_num_t[i]); b_rdy = 1'b1; b_commit = 2'(b_cm_t[i]);
         #2;
         chk($sformatf("m4 r%0d pop", i), int'(b_pop), b_pop_e[i]);
         chk($sformatf("m4 r%0d slot", i), int'(b_slot), b_slot_e[i]);
         chk($sformatf("m4 r%0d inflight", i), int'(b_inflight), b_inf_e[i]);
         chk($sformatf("m4 r%0d state", i), int'(b_state), 0);
      end
      @(negedge clk_i);
      b_rdy = 1'b0; b_commit = 2'd0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
